// File: rtl/booth_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : booth_mult_pkg
// Description : Shared types, defaults and helpers for the sequential Booth
//               multiplier controller and its combinational step unit.
// Revision    : 1.0 - initial release
// ============================================================================
package booth_mult_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Controller states, explicitly 2-bit encoded
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the step counter; holds 0..WIDTH-1 (at least one bit)
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_mult_mux2.sv
`default_nettype none
// ============================================================================
// Module      : booth_mult_mux2
// Description : Generic 2:1 multiplexer (sel=0 -> in0, sel=1 -> in1).
// Revision    : 1.0 - initial release
// ============================================================================
module booth_mult_mux2 #(
  parameter int WIDTH = 8
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out
);

  // Plain select
  always_comb begin
    out = sel ? in1 : in0;
  end

endmodule
`default_nettype wire

// File: rtl/booth_step_unit.sv
`default_nettype none
// ============================================================================
// Module      : booth_step_unit
// Description : One radix-2 Booth step: conditional add/subtract of M into
//               the (WIDTH+1)-bit accumulator followed by an arithmetic right
//               shift of {A,Q,q_1}. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_step_unit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   a_in,
  input  logic [WIDTH:0]   m_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic             q1_in,
  output logic [WIDTH:0]   a_out,
  output logic [WIDTH-1:0] q_out,
  output logic             q1_out
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;
  logic [WIDTH:0] w_addsub;
  logic [WIDTH:0] w_res;

  assign w_sum  = a_in + m_in;
  assign w_diff = a_in - m_in;

  // Q0=1 selects subtract (pair 10), Q0=0 selects add (pair 01)
  booth_mult_mux2 #(.WIDTH(WIDTH + 1)) u_mux_addsub (
    .sel (q_in[0]),
    .in0 (w_sum),
    .in1 (w_diff),
    .out (w_addsub)
  );

  // Pairs 00 and 11 leave the accumulator untouched
  booth_mult_mux2 #(.WIDTH(WIDTH + 1)) u_mux_keep (
    .sel (q_in[0] ^ q1_in),
    .in0 (a_in),
    .in1 (w_addsub),
    .out (w_res)
  );

  // Arithmetic right shift of the concatenation {A,Q,q_1}
  always_comb begin
    a_out  = {w_res[WIDTH], w_res[WIDTH:1]};
    q_out  = {w_res[0], q_in[WIDTH-1:1]};
    q1_out = q_in[0];
  end

endmodule
`default_nettype wire

// File: rtl/booth_seq_multiplier_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : booth_seq_multiplier_ctrl
// Description : Sequential radix-2 Booth multiplier controller. Accepts
//               signed operands on start in IDLE, runs one Booth step per
//               clock for WIDTH clocks, then presents a registered signed
//               2*WIDTH product with a one-cycle done pulse.
//               Optional: define BOOTH_MULT_ABORT_EN to add an abort input
//               that cancels a running multiply without touching product.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_seq_multiplier_ctrl
  import booth_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
`ifdef BOOTH_MULT_ABORT_EN
  input  logic               abort,
`endif
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int                 c_cnt_w = cnt_width(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

  state_t               r_state;
  state_t               w_next_state;
  logic [WIDTH:0]       r_a;
  logic [WIDTH:0]       r_m;
  logic [WIDTH-1:0]     r_q;
  logic                 r_q1;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [2*WIDTH-1:0]   r_product;
  logic [WIDTH:0]       w_a_nxt;
  logic [WIDTH-1:0]     w_q_nxt;
  logic                 w_q1_nxt;
  logic                 w_last;
  logic                 w_abort;

`ifdef BOOTH_MULT_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_last = (r_cnt == c_last);

  booth_step_unit #(.WIDTH(WIDTH)) u_step (
    .a_in   (r_a),
    .m_in   (r_m),
    .q_in   (r_q),
    .q1_in  (r_q1),
    .a_out  (w_a_nxt),
    .q_out  (w_q_nxt),
    .q1_out (w_q1_nxt)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic; abort wins over the final step
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = RUN;
      RUN: begin
        if (w_abort)     w_next_state = IDLE;
        else if (w_last) w_next_state = DONE;
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = (r_state == RUN) || (r_state == DONE);
    done = (r_state == DONE);
  end

  // Operand load, Booth step sequencing and product capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_m       <= '0;
      r_q       <= '0;
      r_q1      <= 1'b0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a   <= '0;
            r_m   <= {multiplicand[WIDTH-1], multiplicand};
            r_q   <= multiplier;
            r_q1  <= 1'b0;
            r_cnt <= '0;
          end
        end
        RUN: begin
          r_a   <= w_a_nxt;
          r_q   <= w_q_nxt;
          r_q1  <= w_q1_nxt;
          r_cnt <= r_cnt + 1'b1;
          // Product is taken straight from the final step's result
          if (w_last && !w_abort) r_product <= {w_a_nxt[WIDTH-1:0], w_q_nxt};
        end
        default: ;
      endcase
    end
  end

  assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_booth_seq_multiplier_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_seq_multiplier_ctrl
// Description : Directed self-checking bench for booth_seq_multiplier_ctrl
//               (WIDTH=8) with hand-computed products and timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_seq_multiplier_ctrl;

  localparam int WIDTH = 8;

  logic              clk;
  logic              rst_n;
  logic              start;
`ifdef BOOTH_MULT_ABORT_EN
  logic              abort;
`endif
  logic [WIDTH-1:0]  multiplicand;
  logic [WIDTH-1:0]  multiplier;
  logic              busy;
  logic              done;
  logic [2*WIDTH-1:0] product;

  int errors = 0;
  int checks = 0;

  booth_seq_multiplier_ctrl #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
`ifdef BOOTH_MULT_ABORT_EN
    .abort        (abort),
`endif
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one multiply and wait (bounded) for done; reports observations
  task automatic run_op(input logic [7:0] m, input logic [7:0] q,
                        output int lat, output logic [15:0] p,
                        output logic busy_at_done, output logic busy_after,
                        output logic done_after);
    @(negedge clk);
    start = 1'b1; multiplicand = m; multiplier = q;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    multiplicand = 8'($urandom); multiplier = 8'($urandom);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    p = product; busy_at_done = busy;
    @(negedge clk);
    busy_after = busy; done_after = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (product !== 16'h0000) begin errors++; $display("FAIL reset_product got=%h exp=0000", product); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_timing();
    int lat; logic [15:0] p; logic bd, ba, da;
    run_op(8'd3, 8'd5, lat, p, bd, ba, da);
    checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency got=%0d exp=8", lat); end
    checks++; if (p !== 16'h000F) begin errors++; $display("FAIL basic_product got=%h exp=000F", p); end
    checks++; if (bd !== 1'b1) begin errors++; $display("FAIL basic_busy_at_done got=%b exp=1", bd); end
    checks++; if (ba !== 1'b0) begin errors++; $display("FAIL basic_busy_after got=%b exp=0", ba); end
    checks++; if (da !== 1'b0) begin errors++; $display("FAIL basic_done_width got=%b exp=0", da); end
  endtask

  task automatic test_corners();
    logic [7:0]  ms [4] = '{8'h80, 8'h80, 8'hFF, 8'h7F};
    logic [7:0]  qs [4] = '{8'h80, 8'h7F, 8'hFF, 8'h7F};
    logic [15:0] ex [4] = '{16'h4000, 16'hC080, 16'h0001, 16'h3F01};
    int lat; logic [15:0] p; logic bd, ba, da;
    for (int i = 0; i < 4; i++) begin
      run_op(ms[i], qs[i], lat, p, bd, ba, da);
      checks++;
      if (p !== ex[i]) begin
        errors++; $display("FAIL corner_%0d got=%h exp=%h", i, p, ex[i]);
      end
    end
  endtask

  task automatic test_zero();
    int lat; logic [15:0] p; logic bd, ba, da;
    run_op(8'h00, 8'h5A, lat, p, bd, ba, da);
    checks++; if (lat !== 8) begin errors++; $display("FAIL zero_latency got=%0d exp=8", lat); end
    checks++; if (p !== 16'h0000) begin errors++; $display("FAIL zero_product got=%h exp=0000", p); end
  endtask

  task automatic test_start_ignored();
    int n; int extra;
    @(negedge clk);
    start = 1'b1; multiplicand = 8'd6; multiplier = 8'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      // Pulse a competing request mid-run
      start = (n == 2 || n == 5); multiplicand = 8'd2; multiplier = 8'd2;
      @(posedge clk); n++;
      @(negedge clk);
    end
    start = 1'b0;
    checks++; if (n !== 8) begin errors++; $display("FAIL ignore_latency got=%0d exp=8", n); end
    checks++; if (product !== 16'h002A) begin errors++; $display("FAIL ignore_product got=%h exp=002A", product); end
    extra = 0;
    repeat (12) begin @(posedge clk); @(negedge clk); if (done) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL ignore_second_done got=%0d exp=0", extra); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [15:0] p; logic bd, ba, da;
    @(negedge clk);
    start = 1'b1; multiplicand = 8'd9; multiplier = 8'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done got=%b exp=0", done); end
    checks++; if (product !== 16'h0000) begin errors++; $display("FAIL midreset_product got=%h exp=0000", product); end
    run_op(8'd9, 8'd9, lat, p, bd, ba, da);
    checks++; if (p !== 16'h0051) begin errors++; $display("FAIL midreset_rerun got=%h exp=0051", p); end
  endtask

  task automatic test_back_to_back();
    int nd; int pos [3]; logic [15:0] last_p;
    nd = 0; last_p = '0;
    @(negedge clk);
    start = 1'b1; multiplicand = 8'd4; multiplier = 8'd5;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        if (nd < 3) pos[nd] = k;
        nd++; last_p = product;
      end
    end
    start = 1'b0;
    checks++; if (nd !== 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", nd); end
    if (nd >= 3) begin
      checks++;
      if (pos[0] !== 8 || pos[1] !== 18 || pos[2] !== 28) begin
        errors++; $display("FAIL b2b_spacing got=%0d,%0d,%0d exp=8,18,28", pos[0], pos[1], pos[2]);
      end
    end
    checks++; if (last_p !== 16'h0014) begin errors++; $display("FAIL b2b_product got=%h exp=0014", last_p); end
    repeat (3) @(negedge clk);
  endtask

`ifdef BOOTH_MULT_ABORT_EN
  task automatic test_abort();
    int lat; int extra; logic [15:0] p; logic bd, ba, da;
    run_op(8'd6, 8'd7, lat, p, bd, ba, da);
    checks++; if (p !== 16'h002A) begin errors++; $display("FAIL abort_prior got=%h exp=002A", p); end
    @(negedge clk);
    start = 1'b1; multiplicand = 8'hFB; multiplier = 8'd6;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    extra = 0;
    repeat (10) begin if (done) extra++; @(posedge clk); @(negedge clk); end
    checks++; if (extra !== 0) begin errors++; $display("FAIL abort_done got=%0d exp=0", extra); end
    checks++; if (product !== 16'h002A) begin errors++; $display("FAIL abort_product got=%h exp=002A", product); end
    run_op(8'hFB, 8'd6, lat, p, bd, ba, da);
    checks++; if (p !== 16'hFFE2) begin errors++; $display("FAIL abort_rerun got=%h exp=FFE2", p); end
  endtask
`endif

  initial begin
    start = 1'b0; multiplicand = '0; multiplier = '0; rst_n = 1'b0;
`ifdef BOOTH_MULT_ABORT_EN
    abort = 1'b0;
`endif
    test_reset();
    test_basic_timing();
    test_corners();
    test_zero();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
`ifdef BOOTH_MULT_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
